// File: rtl/mac_pkg.sv
// Shared MAC stream types: arbiter state encoding and the common stream beat struct.
package mac_pkg;

  localparam int unsigned MacDataW = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PACKET = 2'd1,
    S_IFG    = 2'd2
  } state_t;

  typedef struct packed {
    logic                startofpacket;
    logic                endofpacket;
    logic                valid;
    logic                error;
    logic [MacDataW-1:0] data;
  } stream_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from rr_ptr_i+1 with wrap.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   rr_ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              any_req_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = IdxW'((32'(rr_ptr_i) + off) % NumReq);
      if (!found && req_i[cand]) begin
        found            = 1'b1;
        gnt_o[cand]      = 1'b1;
        gnt_idx_o        = cand;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin scheduler onto the MAC transmit stream with inter-frame gap.
// Optional build macro MAC_TX_ARB_PRIO0_EN makes requester 0 strict high priority.
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic                       mac_clk,
  input  logic                       mac_rst_n,
  input  logic [NUM_REQ-1:0]         req_startofpacket,
  input  logic [NUM_REQ-1:0]         req_endofpacket,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_error,
  input  logic [DATA_WIDTH-1:0]      req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_startofpacket,
  output logic                       tx_endofpacket,
  output logic                       tx_valid,
  output logic                       tx_error,
  output logic [DATA_WIDTH-1:0]      tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_active,
  output logic                       drop_pulse
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] IfgLast = CntW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [IdxW-1:0]   grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   ifg_cnt_q, ifg_cnt_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] orphan;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_any;

  assign eligible = req_valid & req_startofpacket;
  assign orphan   = req_valid & ~req_startofpacket;

`ifdef MAC_TX_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation, so keep it out of the round-robin pool.
  assign arb_req = eligible & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
  assign arb_req = eligible;
`endif

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i     (arb_req),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_req_o (arb_any)
  );

  // Data path: zero-latency mux of the granted requester; orphans flushed outside a frame.
  always_comb begin
    tx_startofpacket = 1'b0;
    tx_endofpacket   = 1'b0;
    tx_valid         = 1'b0;
    tx_error         = 1'b0;
    tx_data          = '0;
    req_ready        = '0;
    drop_pulse       = 1'b0;
    case (state_q)
      S_PACKET: begin
        tx_startofpacket       = req_startofpacket[grant_idx_q];
        tx_endofpacket         = req_endofpacket[grant_idx_q];
        tx_valid               = req_valid[grant_idx_q];
        tx_error               = req_error[grant_idx_q];
        tx_data                = req_data[grant_idx_q];
        req_ready[grant_idx_q] = tx_ready;
      end
      default: begin
        req_ready  = orphan;
        drop_pulse = |orphan;
      end
    endcase
    // State resets asynchronously; these two also depend on live inputs, so gate them too.
    if (!mac_rst_n) begin
      req_ready  = '0;
      drop_pulse = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    ifg_cnt_d   = ifg_cnt_q;
    case (state_q)
      S_IDLE: begin
`ifdef MAC_TX_ARB_PRIO0_EN
        if (eligible[0]) begin
          grant_idx_d = '0;
          state_d     = S_PACKET;
        end else if (arb_any) begin
          grant_idx_d = arb_idx;
          rr_ptr_d    = arb_idx;
          state_d     = S_PACKET;
        end
`else
        if (arb_any) begin
          grant_idx_d = arb_idx;
          rr_ptr_d    = arb_idx;
          state_d     = S_PACKET;
        end
`endif
      end
      S_PACKET: begin
        if (tx_valid && tx_ready && tx_endofpacket) begin
          ifg_cnt_d = '0;
          state_d   = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_cnt_q == IfgLast) begin
          ifg_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= IdxW'(NUM_REQ - 1);
      ifg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      ifg_cnt_q   <= ifg_cnt_d;
    end
  end

  assign grant_idx    = grant_idx_q;
  assign grant_active = (state_q == S_PACKET);

  a_gnt_onehot: assert property (@(posedge mac_clk) disable iff (!mac_rst_n)
    arb_any |-> $onehot(arb_gnt));

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed self-checking bench for mac_tx_arbiter (4 requesters, 8-bit data, 12-cycle gap).
module tb_mac_tx_arbiter;

  localparam int NReq = 4;
  localparam int Ifg  = 12;

  logic       clk = 1'b0;
  logic       mac_rst_n;
  logic [3:0] sop, eop, vld, err;
  logic [7:0] data [NReq];
  logic [3:0] req_ready;
  logic       tx_sop, tx_eop, tx_valid, tx_error;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] grant_idx;
  logic       grant_active, drop_pulse;

  int checks = 0;
  int errors = 0;
  int g_seq[$];
  int exp_q[$];

  always #5 clk = ~clk;

  mac_tx_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (NReq),
    .IFG_CYCLES (Ifg)
  ) dut (
    .mac_clk           (clk),
    .mac_rst_n         (mac_rst_n),
    .req_startofpacket (sop),
    .req_endofpacket   (eop),
    .req_valid         (vld),
    .req_error         (err),
    .req_data          (data),
    .req_ready         (req_ready),
    .tx_startofpacket  (tx_sop),
    .tx_endofpacket    (tx_eop),
    .tx_valid          (tx_valid),
    .tx_error          (tx_error),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .grant_idx         (grant_idx),
    .grant_active      (grant_active),
    .drop_pulse        (drop_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    vld = '0; sop = '0; eop = '0; err = '0;
    repeat (n) step();
  endtask

  task automatic chk_seq(input string tag);
    int obs;
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = (k < g_seq.size()) ? g_seq[k] : -1;
      chk(tag, obs, exp_q[k]);
    end
  endtask

  // Requesters in mask hold back-to-back frames; beat data = {id, beat index}, error on beat 3.
  task automatic run_frames(input logic [3:0] mask, input int nframes, input int beats,
                            input bit toggle);
    int cnt[NReq];
    int frames, cyc, last_eop, cur_id, cur_beat, budget;
    bit in_frame;
    logic [3:0] acc, exp_rdy;
    frames = 0; cyc = 0; last_eop = -1; cur_id = 0; cur_beat = 0; in_frame = 0;
    budget = nframes * (2 * beats + Ifg + 4) + 20;
    g_seq.delete();
    for (int r = 0; r < NReq; r++) cnt[r] = 0;
    while (frames < nframes && cyc < budget) begin
      for (int r = 0; r < NReq; r++) begin
        vld[r]  = mask[r];
        sop[r]  = (cnt[r] == 0);
        eop[r]  = (cnt[r] == beats - 1);
        err[r]  = (cnt[r] == 3);
        data[r] = {r[1:0], cnt[r][5:0]};
      end
      tx_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (tx_valid && tx_sop && !in_frame) begin
        in_frame = 1;
        cur_id   = int'(tx_data[7:6]);
        cur_beat = 0;
        g_seq.push_back(cur_id);
        chk("grant_idx_at_sop", grant_idx, cur_id);
        chk("grant_active_at_sop", grant_active, 1);
        if (last_eop >= 0) chk("eop_to_sop_cycles", cyc - last_eop, Ifg + 2);
      end
      exp_rdy = (in_frame && tx_ready) ? 4'(1 << cur_id) : 4'b0;
      chk("req_ready", req_ready, exp_rdy);
      chk("tx_valid", tx_valid, in_frame);
      acc = req_ready & vld;
      if (in_frame && tx_ready && tx_valid) begin
        chk("tx_beat", {tx_sop, tx_eop, tx_error, tx_data},
            {cur_beat == 0, cur_beat == beats - 1, cur_beat == 3, cur_id[1:0], cur_beat[5:0]});
        cur_beat++;
        if (cur_beat == beats) begin
          in_frame = 0;
          frames++;
          last_eop = cyc;
        end
      end
      step();
      cyc++;
      for (int r = 0; r < NReq; r++) if (acc[r]) cnt[r] = (cnt[r] + 1) % beats;
    end
    vld = '0; sop = '0; eop = '0; err = '0;
    tx_ready = 1'b1;
    chk("frames_done", frames, nframes);
  endtask

  initial begin
    mac_rst_n = 1'b0;
    tx_ready  = 1'b1;
    vld = '0; sop = '0; eop = '0; err = '0;
    for (int r = 0; r < NReq; r++) data[r] = '0;
    repeat (3) step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    mac_rst_n = 1'b1;
    step();

    // Single requester, two 64-beat frames to expose the gap.
    run_frames(4'b0100, 2, 64, 1'b0);
    exp_q = {2, 2};
    chk_seq("single_grant");

    // Fresh reset so rr_ptr starts at NUM_REQ-1.
    mac_rst_n = 1'b0;
    step();
    mac_rst_n = 1'b1;
    step();
    run_frames(4'b1111, 6, 10, 1'b0);
    exp_q = {0, 1, 2, 3, 0, 1};
    chk_seq("fair_grant");

    idle(16);
    run_frames(4'b0010, 1, 20, 1'b1);
    exp_q = {1};
    chk_seq("bp_grant");

    // Orphan beat in S_IDLE.
    idle(16);
    vld[3] = 1'b1; sop[3] = 1'b0; data[3] = 8'hAA;
    #1;
    chk("orphan_ready", req_ready, 4'b1000);
    chk("orphan_drop", drop_pulse, 1);
    chk("orphan_tx_valid", tx_valid, 0);
    step();
    vld = '0;
    #1;
    chk("orphan_drop_end", drop_pulse, 0);
    chk("orphan_ready_end", req_ready, 0);
    chk("orphan_tx_after", tx_valid, 0);
    chk("orphan_active", grant_active, 0);
    step();

    // Reset while beat 5 of a 10-beat frame from req 0 is on tx.
    vld[0] = 1'b1; sop[0] = 1'b1; eop[0] = 1'b0; data[0] = 8'd0;
    step();
    for (int b = 0; b < 5; b++) begin
      sop[0]  = (b == 0);
      data[0] = 8'(b);
      step();
    end
    sop[0] = 1'b0; data[0] = 8'd5;
    #1;
    chk("mid_beat5", {tx_valid, tx_data}, {1'b1, 8'd5});
    mac_rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_active", grant_active, 0);
    chk("mid_rst_drop", drop_pulse, 0);
    step();
    vld = '0;
    mac_rst_n = 1'b1;
    step();
    run_frames(4'b0101, 1, 2, 1'b0);
    exp_q = {0};
    chk_seq("post_rst_grant");

    idle(16);
    run_frames(4'b0011, 4, 2, 1'b0);
`ifdef MAC_TX_ARB_PRIO0_EN
    exp_q = {0, 0, 0, 0};
`else
    exp_q = {1, 0, 1, 0};
`endif
    chk_seq("pair_grant");
    idle(16);
    run_frames(4'b0010, 1, 2, 1'b0);
    exp_q = {1};
    chk_seq("req1_alone_grant");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
